// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: program memory loaded while idle, asynchronously read at pc_in,
// and presented to decode through one registered IF/ID slot with stall, flush and halt-on-zero.
module instr_fetch_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              halted,
  output logic [ADDR_W:0]   fetch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {(ADDR_W+1){1'b1}};

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   instr_reg, instr_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic                valid_reg, valid_next;
  logic                halted_reg, halted_next;
  logic [ADDR_W:0]     cnt_reg, cnt_next;
  logic                mem_we;
  logic [DATA_W-1:0]   fetch_word;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Program memory is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[prog_addr] <= prog_data;
  end

  assign fetch_word = mem[pc_in];

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    cnt_next    = cnt_reg;
    mem_we      = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_we     = prog_we & reset;
        valid_next = 1'b0;
        if (run)
          state_next = RUN;
      end
      RUN: begin
        if (flush) begin
          valid_next = 1'b0;
        end else if (stall) begin
          // slot held; this cycle's pc_in is dropped
        end else if (fetch_word == '0) begin
          valid_next  = 1'b0;
          halted_next = 1'b1;
          state_next  = HALT;
        end else begin
          instr_next = fetch_word;
          pc_next    = pc_in;
          valid_next = 1'b1;
          if (cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + 1'b1;
        end
      end
      HALT: begin
        valid_next  = 1'b0;
        halted_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg  <= IDLE;
      instr_reg  <= '0;
      pc_reg     <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      instr_reg  <= instr_next;
      pc_reg     <= pc_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign instr_out = instr_reg;
  assign pc_out    = pc_reg;
  assign valid_out = valid_reg;
  assign halted    = halted_reg;
  assign fetch_cnt = cnt_reg;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the fetch stage.
module tb_instr_fetch_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [5:0]  pc_in;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        run;
  logic        stall;
  logic        flush;
  logic [31:0] instr_out;
  logic [5:0]  pc_out;
  logic        valid_out;
  logic        halted;
  logic [6:0]  fetch_cnt;

  instr_fetch_stage dut (
    .CLK(CLK), .reset(reset), .pc_in(pc_in), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .stall(stall), .flush(flush), .instr_out(instr_out),
    .pc_out(pc_out), .valid_out(valid_out), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  // behavioural model
  logic [31:0] m_mem [64];
  logic [31:0] m_instr;
  int          m_pc, m_cnt;
  bit          m_valid, m_halted, m_running, m_stopped;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_running = 0; m_stopped = 0; m_instr = 0; m_pc = 0;
      m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (m_stopped) begin
      // frozen until reset
    end else if (m_running) begin
      if (flush)
        m_valid = 0;
      else if (stall)
        ;
      else if (m_mem[pc_in] == 0) begin
        m_valid = 0; m_halted = 1; m_stopped = 1;
      end else begin
        m_instr = m_mem[pc_in]; m_pc = pc_in; m_valid = 1;
        if (m_cnt < 127) m_cnt++;
      end
    end else begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (run) m_running = 1;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    n_cycle++;
    $display("cyc %0d rst=%0b run=%0b we=%0b pc_in=%0d st=%0b fl=%0b -> instr=%h pc=%0d v=%0b h=%0b cnt=%0d",
             n_cycle, reset, run, prog_we, pc_in, stall, flush, instr_out, pc_out, valid_out, halted, fetch_cnt);
    check("instr_out", instr_out, m_instr);
    check("pc_out", {26'd0, pc_out}, m_pc);
    check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("fetch_cnt", {25'd0, fetch_cnt}, m_cnt);
  endtask

  task automatic idle_inputs();
    prog_we = 0; prog_addr = 0; prog_data = 0; run = 0; stall = 0; flush = 0; pc_in = 0;
  endtask

  task automatic write_word(input int addr, input logic [31:0] data, input bit with_run);
    prog_we = 1; prog_addr = addr[5:0]; prog_data = data; run = with_run;
    cycle();
    prog_we = 0; run = 0;
  endtask

  task automatic fetch(input int pc, input bit st, input bit fl);
    pc_in = pc[5:0]; stall = st; flush = fl;
    cycle();
    stall = 0; flush = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    cycle();
    reset = 1;
  endtask

  logic [31:0] word4;

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_instr = 0; m_pc = 0; m_cnt = 0; m_valid = 0; m_halted = 0; m_running = 0; m_stopped = 0;
    idle_inputs();
    reset = 0;
    cycle();
    cycle();
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    check("reset_instr", instr_out, 32'd0);
    reset = 1;

    // load program: random nonzero words, then the directed ones, halt word written with run
    for (int i = 0; i < 64; i++) write_word(i, $urandom | 32'h1, 1'b0);
    write_word(0, 32'h11, 1'b0);
    write_word(1, 32'h22, 1'b0);
    write_word(2, 32'h33, 1'b0);
    write_word(3, 32'h44, 1'b0);
    word4 = m_mem[4];
    write_word(5, 32'h0, 1'b1);

    for (int p = 0; p < 4; p++) fetch(p, 0, 0);
    check("seq_instr", instr_out, 32'h44);
    check("seq_cnt", {25'd0, fetch_cnt}, 32'd4);

    // program writes are ignored while running
    prog_we = 1; prog_addr = 0; prog_data = 32'hFF;
    fetch(0, 0, 0);
    prog_we = 0;
    fetch(0, 0, 0);
    check("we_ignored", instr_out, 32'h11);

    fetch(1, 0, 0);
    fetch(2, 1, 0);
    fetch(3, 1, 0);
    check("stall_instr", instr_out, 32'h22);
    check("stall_pc", {26'd0, pc_out}, 32'd1);
    check("stall_cnt", {25'd0, fetch_cnt}, 32'd7);
    fetch(4, 0, 0);
    check("after_stall", instr_out, word4);
    fetch(5, 1, 1);
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    check("flush_instr", instr_out, word4);
    fetch(5, 0, 0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      prog_we = 1; prog_addr = 0; prog_data = 32'hFF; run = 1;
      fetch($urandom_range(0, 63), 0, 0);
    end
    idle_inputs();
    check("halt_frozen", instr_out, word4);

    pulse_reset();
    check("rst_halted", {31'd0, halted}, 32'd0);
    run = 1;
    cycle();
    run = 0;
    fetch(0, 0, 0);
    check("refetch0", instr_out, 32'h11);

    // long sequential run with wrap-around to reach counter saturation
    pulse_reset();
    write_word(5, 32'h55, 1'b1);
    for (int i = 0; i < 140; i++) fetch(i % 64, 0, 0);
    check("cnt_sat", {25'd0, fetch_cnt}, 32'd127);

    // randomized traffic; mem[63] halts, occasional resets restart
    pulse_reset();
    write_word(63, 32'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      reset     = ($urandom_range(0, 29) != 0);
      run       = ($urandom_range(0, 3) == 0);
      prog_we   = reset && ($urandom_range(0, 2) == 0);
      prog_addr = $urandom_range(0, 63);
      prog_data = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      fetch($urandom_range(0, 63), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
    end
    idle_inputs();
    reset = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
